l1pa_regfile_loader: RTL and testbench

Hardware preloader for the L1PA register file of the memShare controller. It accepts a byte-oriented configuration stream over a valid/ready handshake and packs the beats into L1PA_SPR pages. It then issues single-cycle writes on the regType0 write port (waddr/wdata/we) of the memShare control wrapper, replacing file-based preloading in system builds. It sits directly upstream of the controller's register file and reports completion and error status to the configuration master.

---
 rtl/l1pa_regfile_loader.sv | 148 ++++++++++++++
 tb/tb_l1pa_regfile_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l1pa_regfile_loader.sv
// Packs a byte stream into L1PA_SPR pages and writes them through the regType0 port.
// Optional L1PA_LOADER_CHECKSUM_EN adds a trailing XOR beat that is compared against the accepted page beats.
module l1pa_regfile_loader #(
  parameter int L1PA_REGFILE_PAGE_NUM   = 16,
  parameter int L1PA_REGFILE_PAGE_WIDTH = 20,
  parameter int L1PA_REGFILE_ADDR_WIDTH = $clog2(L1PA_REGFILE_PAGE_NUM),
  parameter int STREAM_WIDTH            = 8
) (
  input  logic                               sys_clk,
  input  logic                               rst,
  input  logic                               start_i,
  input  logic [L1PA_REGFILE_ADDR_WIDTH-1:0] page_base_i,
  input  logic [L1PA_REGFILE_ADDR_WIDTH:0]   page_cnt_i,
  input  logic [STREAM_WIDTH-1:0]            s_data_i,
  input  logic                               s_valid_i,
  output logic                               s_ready_o,
  output logic [L1PA_REGFILE_ADDR_WIDTH-1:0] regType0_waddr_o,
  output logic [L1PA_REGFILE_PAGE_WIDTH-1:0] regType0_wdata_o,
  output logic                               regType0_we_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               err_o
);
  localparam int AW    = L1PA_REGFILE_ADDR_WIDTH;
  localparam int PW    = L1PA_REGFILE_PAGE_WIDTH;
  localparam int SW    = STREAM_WIDTH;
  localparam int BEATS = (PW + SW - 1) / SW;
  localparam int SRW   = BEATS * SW;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0]   LAST_BEAT = BW'(BEATS - 1);
  localparam logic [AW+1:0]   PAGE_LIM  = (AW + 2)'(L1PA_REGFILE_PAGE_NUM);

`ifdef L1PA_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, ASSEMBLE, WRITE, CHECK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, ASSEMBLE, WRITE, DONE} state_t;
`endif

  state_t          state, stateNext;
  logic [AW-1:0]   pagePtr;
  logic [AW:0]     remCnt;
  logic [BW-1:0]   beatCnt;
  logic [SRW-1:0]  shiftReg, pageNext;
  logic [AW-1:0]   waddrQ;
  logic [PW-1:0]   wdataQ;
  logic            errQ;
  logic [AW+1:0]   rangeSum;
  logic            rangeBad, beatFire, lastBeat, lastPage;
`ifdef L1PA_LOADER_CHECKSUM_EN
  logic [SW-1:0]   xorAcc;
`endif

  // Sum is two bits wider than the address so base+cnt can never overflow the check.
  assign rangeSum = {2'b00, page_base_i} + {1'b0, page_cnt_i};
  assign rangeBad = rangeSum > PAGE_LIM;
  assign beatFire = s_valid_i && s_ready_o;
  assign lastBeat = beatCnt == LAST_BEAT;
  assign lastPage = remCnt == (AW + 1)'(1);

  always_comb begin
    pageNext = shiftReg;
    pageNext[beatCnt*SW +: SW] = s_data_i;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (start_i) stateNext = (rangeBad || page_cnt_i == '0) ? DONE : ASSEMBLE;
      ASSEMBLE: if (beatFire && lastBeat) stateNext = WRITE;
`ifdef L1PA_LOADER_CHECKSUM_EN
      WRITE:    stateNext = lastPage ? CHECK : ASSEMBLE;
      CHECK:    if (beatFire) stateNext = DONE;
`else
      WRITE:    stateNext = lastPage ? DONE : ASSEMBLE;
`endif
      DONE:     stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  always_comb begin
    s_ready_o     = state == ASSEMBLE;
`ifdef L1PA_LOADER_CHECKSUM_EN
    s_ready_o     = s_ready_o || state == CHECK;
`endif
    regType0_we_o = state == WRITE;
    busy_o        = state != IDLE;
    done_o        = state == DONE;
  end

  assign regType0_waddr_o = waddrQ;
  assign regType0_wdata_o = wdataQ;
  assign err_o            = errQ;

  // Write address/data are latched on the final beat so they hold between write strobes.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      pagePtr  <= '0;
      remCnt   <= '0;
      beatCnt  <= '0;
      shiftReg <= '0;
      waddrQ   <= '0;
      wdataQ   <= '0;
      errQ     <= 1'b0;
`ifdef L1PA_LOADER_CHECKSUM_EN
      xorAcc   <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start_i) begin
          pagePtr <= page_base_i;
          remCnt  <= page_cnt_i;
          beatCnt <= '0;
          errQ    <= rangeBad;
`ifdef L1PA_LOADER_CHECKSUM_EN
          xorAcc  <= '0;
`endif
        end
        ASSEMBLE: if (beatFire) begin
          shiftReg <= pageNext;
`ifdef L1PA_LOADER_CHECKSUM_EN
          xorAcc   <= xorAcc ^ s_data_i;
`endif
          if (lastBeat) begin
            beatCnt <= '0;
            waddrQ  <= pagePtr;
            wdataQ  <= pageNext[PW-1:0];
          end else begin
            beatCnt <= beatCnt + BW'(1);
          end
        end
        WRITE: begin
          pagePtr <= pagePtr + AW'(1);
          remCnt  <= remCnt - (AW + 1)'(1);
        end
`ifdef L1PA_LOADER_CHECKSUM_EN
        CHECK: if (beatFire && s_data_i != xorAcc) errQ <= 1'b1;
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_l1pa_regfile_loader.sv
// Directed bench for l1pa_regfile_loader; honours L1PA_LOADER_CHECKSUM_EN when defined.
module tb_l1pa_regfile_loader;
  logic        sys_clk = 1'b0;
  logic        rst, start_i, s_valid_i;
  logic [3:0]  page_base_i;
  logic [4:0]  page_cnt_i;
  logic [7:0]  s_data_i;
  logic        s_ready_o, regType0_we_o, busy_o, done_o, err_o;
  logic [3:0]  regType0_waddr_o;
  logic [19:0] regType0_wdata_o;

  int checks = 0;
  int failures = 0;
  logic [3:0]  wrA[$];
  logic [19:0] wrD[$];
  int hsCnt = 0;

  l1pa_regfile_loader dut (
    .sys_clk(sys_clk), .rst(rst), .start_i(start_i), .page_base_i(page_base_i),
    .page_cnt_i(page_cnt_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .regType0_waddr_o(regType0_waddr_o), .regType0_wdata_o(regType0_wdata_o),
    .regType0_we_o(regType0_we_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (regType0_we_o) begin
      wrA.push_back(regType0_waddr_o);
      wrD.push_back(regType0_wdata_o);
    end
    if (s_valid_i && s_ready_o) hsCnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, "_ready"}, s_ready_o, 0);
    chk({tag, "_we"}, regType0_we_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
  endtask

  // Full load through the handshake; pages come from a seeded byte pattern.
  task automatic runLoad(input logic [3:0] base, input logic [4:0] cnt, input logic [7:0] seed,
                         input bit stall, input bit corrupt);
    logic [7:0]  beats[$];
    logic [7:0]  xr;
    logic [23:0] pg;
    int nBeats, g, cyc, startW;
    bit doneSeen, acc;
    xr = 8'h00;
    nBeats = cnt * 3;
    for (int i = 0; i < nBeats; i++) begin
      beats.push_back(8'(seed + i * 37));
      xr ^= beats[i];
    end
`ifdef L1PA_LOADER_CHECKSUM_EN
    beats.push_back(corrupt ? (xr ^ 8'h01) : xr);
    nBeats++;
`endif
    startW = wrA.size();
    start_i = 1'b1; page_base_i = base; page_cnt_i = cnt;
    tick();
    start_i = 1'b0;
    chk("start_busy", busy_o, 1);
    chk("start_ready", s_ready_o, 1);
    chk("start_errclr", err_o, 0);
    g = 0; cyc = 0; doneSeen = 0;
    while (!doneSeen && cyc < 600) begin
      s_valid_i = (g < nBeats) && (!stall || cyc[0]);
      s_data_i  = (g < nBeats) ? beats[g] : 8'h00;
      acc = s_valid_i && s_ready_o;
      tick();
      cyc++;
      if (acc) g++;
      if (done_o) doneSeen = 1;
    end
    s_valid_i = 1'b0;
    chk("load_done_seen", doneSeen, 1);
    chk("load_beats_used", g, nBeats);
    chk("load_nwrites", wrA.size() - startW, cnt);
    for (int p = 0; p < cnt && startW + p < wrA.size(); p++) begin
      pg = {beats[3*p+2], beats[3*p+1], beats[3*p]};
      chk($sformatf("load_addr%0d", p), wrA[startW+p], base + p);
      chk($sformatf("load_data%0d", p), wrD[startW+p], pg[19:0]);
    end
`ifdef L1PA_LOADER_CHECKSUM_EN
    chk("load_err", err_o, corrupt);
`else
    chk("load_err", err_o, 0);
`endif
    tick();
    chk("load_idle_busy", busy_o, 0);
  endtask

  initial begin
    int w0, h0;
    rst = 1'b1; start_i = 1'b0; s_valid_i = 1'b1; s_data_i = 8'h5A;
    page_base_i = '0; page_cnt_i = '0;
    // Reset held with valid asserted: nothing may handshake.
    for (int i = 0; i < 3; i++) begin
      tick();
      chkIdle("rst");
      chk("rst_err", err_o, 0);
      chk("rst_waddr", regType0_waddr_o, 0);
      chk("rst_wdata", regType0_wdata_o, 0);
    end
    chk("rst_handshakes", hsCnt, 0);
    rst = 1'b0; s_valid_i = 1'b0;
    tick();
    chkIdle("idle");

    // Single page, back-to-back beats.
    w0 = wrA.size();
    start_i = 1'b1; page_base_i = 4'd5; page_cnt_i = 5'd1;
    tick();
    start_i = 1'b0;
    chk("sp_busy", busy_o, 1);
    chk("sp_ready", s_ready_o, 1);
    s_valid_i = 1'b1; s_data_i = 8'h21; tick();
    s_data_i = 8'h43; tick();
    s_data_i = 8'h65; tick();
    s_valid_i = 1'b0;
    chk("sp_we", regType0_we_o, 1);
    chk("sp_waddr", regType0_waddr_o, 5);
    chk("sp_wdata", regType0_wdata_o, 20'h54321);
    chk("sp_ready_wr", s_ready_o, 0);
    tick();
`ifdef L1PA_LOADER_CHECKSUM_EN
    chk("sp_chk_ready", s_ready_o, 1);
    s_valid_i = 1'b1; s_data_i = 8'h07; tick();
    s_valid_i = 1'b0;
`endif
    chk("sp_done", done_o, 1);
    chk("sp_we_off", regType0_we_o, 0);
    tick();
    chk("sp_done_off", done_o, 0);
    chk("sp_busy_off", busy_o, 0);
    chk("sp_hold_waddr", regType0_waddr_o, 5);
    chk("sp_hold_wdata", regType0_wdata_o, 20'h54321);
    chk("sp_nwrites", wrA.size() - w0, 1);
    chk("sp_err", err_o, 0);

    // All 16 pages with valid toggling.
    runLoad(4'd0, 5'd16, 8'h13, 1'b1, 1'b0);

    // Zero-count load completes immediately.
    w0 = wrA.size();
    start_i = 1'b1; page_base_i = 4'd4; page_cnt_i = 5'd0;
    tick();
    start_i = 1'b0;
    chk("zc_done", done_o, 1);
    chk("zc_err", err_o, 0);
    tick();
    chk("zc_busy", busy_o, 0);
    chk("zc_nwrites", wrA.size() - w0, 0);

    // Range violation: 14 + 3 > 16.
    w0 = wrA.size();
    start_i = 1'b1; page_base_i = 4'd14; page_cnt_i = 5'd3;
    tick();
    start_i = 1'b0;
    chk("re_done", done_o, 1);
    chk("re_err", err_o, 1);
    chk("re_ready", s_ready_o, 0);
    tick();
    chk("re_done_off", done_o, 0);
    chk("re_busy", busy_o, 0);
    tick();
    chk("re_err_sticky", err_o, 1);
    chk("re_nwrites", wrA.size() - w0, 0);
    // Exactly at the top of the file: 14 + 2 == 16 is legal and clears err.
    runLoad(4'd14, 5'd2, 8'hC4, 1'b0, 1'b0);

    // Reset during the second page of a four-page load.
    w0 = wrA.size();
    start_i = 1'b1; page_base_i = 4'd2; page_cnt_i = 5'd4;
    tick();
    start_i = 1'b0;
    s_valid_i = 1'b1;
    s_data_i = 8'h11; tick();
    s_data_i = 8'h22; tick();
    s_data_i = 8'h33; tick();
    s_valid_i = 1'b0;
    tick();
    s_valid_i = 1'b1; s_data_i = 8'h44; tick();
    rst = 1'b1;
    tick();
    chkIdle("mr");
    chk("mr_waddr", regType0_waddr_o, 0);
    chk("mr_wdata", regType0_wdata_o, 0);
    chk("mr_err", err_o, 0);
    chk("mr_nwrites", wrA.size() - w0, 1);
    chk("mr_first_addr", wrA[w0], 2);
    rst = 1'b0; s_valid_i = 1'b0;
    tick();

    // A start pulse while busy must not restart or queue a load.
    w0 = wrA.size();
    start_i = 1'b1; page_base_i = 4'd8; page_cnt_i = 5'd1;
    tick();
    page_base_i = 4'd0; page_cnt_i = 5'd5;
    tick();
    start_i = 1'b0;
    chk("is_busy", busy_o, 1);
    chk("is_ready", s_ready_o, 1);
    h0 = hsCnt;
    s_valid_i = 1'b1;
    s_data_i = 8'hAA; tick();
    s_data_i = 8'hBB; tick();
    s_data_i = 8'hCC; tick();
    s_valid_i = 1'b0;
    chk("is_waddr", regType0_waddr_o, 8);
    chk("is_wdata", regType0_wdata_o, 20'hCBBAA);
    tick();
`ifdef L1PA_LOADER_CHECKSUM_EN
    s_valid_i = 1'b1; s_data_i = 8'hDD; tick();
    s_valid_i = 1'b0;
`endif
    chk("is_done", done_o, 1);
    tick();
    tick();
    tick();
    chk("is_busy_off", busy_o, 0);
    chk("is_nwrites", wrA.size() - w0, 1);
`ifdef L1PA_LOADER_CHECKSUM_EN
    chk("is_handshakes", hsCnt - h0, 4);
`else
    chk("is_handshakes", hsCnt - h0, 3);
`endif

`ifdef L1PA_LOADER_CHECKSUM_EN
    runLoad(4'd3, 5'd2, 8'h5B, 1'b0, 1'b0);
    runLoad(4'd3, 5'd2, 8'h5B, 1'b0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
